// File: rtl/fpalu_sequencer.sv
// fpalu_sequencer: multicycle issue controller in front of FPALU.
// Latches one FP op, holds it on the FPALU inputs for the op's latency, then captures the result.
// Ports:
//   iclock, irst_n (async, active-low)
//   core side: istart, icontrol, idataa/b, iflush, obusy, odone,
//     oresult and the captured flags onan, ozero, ooverflow, ounderflow, oCompResult
//   FPALU side: ofpa_control, ofpa_dataa/b, ifpa_result and the ifpa_* flags
// Optional macro FPSEQ_STICKY_FLAGS_EN adds ifflags_clr and offlags = {NV,OF,UF}.

package fpalu_sequencer_pkg;
  localparam logic [4:0] FOPADD    = 5'd0;
  localparam logic [4:0] FOPSUB    = 5'd1;
  localparam logic [4:0] FOPMUL    = 5'd2;
  localparam logic [4:0] FOPDIV    = 5'd3;
  localparam logic [4:0] FOPSQRT   = 5'd4;
  localparam logic [4:0] FOPABS    = 5'd5;
  localparam logic [4:0] FOPNEG    = 5'd6;
  localparam logic [4:0] FOPSGNJ   = 5'd7;
  localparam logic [4:0] FOPSGNJN  = 5'd8;
  localparam logic [4:0] FOPSGNJX  = 5'd9;
  localparam logic [4:0] FOPCVTSW  = 5'd10;
  localparam logic [4:0] FOPCVTWS  = 5'd11;
  localparam logic [4:0] FOPCVTSWU = 5'd12;
  localparam logic [4:0] FOPCVTWUS = 5'd13;
  localparam logic [4:0] FOPCEQ    = 5'd14;
  localparam logic [4:0] FOPCLT    = 5'd15;
  localparam logic [4:0] FOPCLE    = 5'd16;
  localparam logic [4:0] FOPMAX    = 5'd17;
  localparam logic [4:0] FOPMIN    = 5'd18;
endpackage

module fpalu_sequencer
  import fpalu_sequencer_pkg::*;
#(
  parameter int LAT_ADDSUB = 7,
  parameter int LAT_MUL    = 5,
  parameter int LAT_DIV    = 6,
  parameter int LAT_SQRT   = 16,
  parameter int LAT_CVT    = 6,
  parameter int LAT_CMP    = 1,
  parameter int LAT_MIN    = 1
) (
  input  logic        iclock,
  input  logic        irst_n,
  input  logic        istart,
  input  logic [4:0]  icontrol,
  input  logic [31:0] idataa,
  input  logic [31:0] idatab,
  input  logic        iflush,
`ifdef FPSEQ_STICKY_FLAGS_EN
  input  logic        ifflags_clr,
  output logic [2:0]  offlags,
`endif
  output logic        obusy,
  output logic        odone,
  output logic [31:0] oresult,
  output logic        onan,
  output logic        ozero,
  output logic        ooverflow,
  output logic        ounderflow,
  output logic        oCompResult,
  output logic [4:0]  ofpa_control,
  output logic [31:0] ofpa_dataa,
  output logic [31:0] ofpa_datab,
  input  logic [31:0] ifpa_result,
  input  logic        ifpa_nan,
  input  logic        ifpa_zero,
  input  logic        ifpa_overflow,
  input  logic        ifpa_underflow,
  input  logic        ifpa_comp
);

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int LAT_MAX =
    imax(imax(imax(LAT_ADDSUB, LAT_MUL),
              imax(LAT_DIV, LAT_SQRT)),
         imax(imax(LAT_CVT, LAT_CMP), LAT_MIN));
  localparam int CW = $clog2(LAT_MAX) + 1;

  if (LAT_ADDSUB < 1 || LAT_MUL < 1 ||
      LAT_DIV < 1 || LAT_SQRT < 1 ||
      LAT_CVT < 1 || LAT_CMP < 1 ||
      LAT_MIN < 1) begin : g_lat_chk
    $error("fpalu_sequencer: LAT_* must be >= 1");
  end

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] lat_m1_d;
  logic          done_q;
  logic [31:0]   res_q;
  logic [4:0]    flg_q;
  logic [4:0]    ctl_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          accept;
  logic          capture;

  logic op_addsub, op_mul, op_div, op_sqrt;
  logic op_cvt, op_cmp;

  assign op_addsub = (icontrol == FOPADD) ||
                     (icontrol == FOPSUB);
  assign op_mul    = (icontrol == FOPMUL);
  assign op_div    = (icontrol == FOPDIV);
  assign op_sqrt   = (icontrol == FOPSQRT);
  assign op_cvt    = (icontrol == FOPCVTSW)  ||
                     (icontrol == FOPCVTWS)  ||
                     (icontrol == FOPCVTSWU) ||
                     (icontrol == FOPCVTWUS);
  assign op_cmp    = (icontrol == FOPCEQ) ||
                     (icontrol == FOPCLT) ||
                     (icontrol == FOPCLE) ||
                     (icontrol == FOPMAX) ||
                     (icontrol == FOPMIN);

  // Counter is preloaded with LAT-1 so a zero count means
  // the FPALU output is valid at this edge.
  always_comb begin
    lat_m1_d = CW'(LAT_MIN - 1);
    unique case (1'b1)
      op_addsub: lat_m1_d = CW'(LAT_ADDSUB - 1);
      op_mul:    lat_m1_d = CW'(LAT_MUL - 1);
      op_div:    lat_m1_d = CW'(LAT_DIV - 1);
      op_sqrt:   lat_m1_d = CW'(LAT_SQRT - 1);
      op_cvt:    lat_m1_d = CW'(LAT_CVT - 1);
      op_cmp:    lat_m1_d = CW'(LAT_CMP - 1);
      default: ;
    endcase
  end

  assign accept  = (state_q == S_IDLE) &&
                   istart && !iflush;
  // Flush on the capture edge wins.
  assign capture = (state_q == S_WAIT) &&
                   !iflush && (cnt_q == '0);

  always_ff @(posedge iclock or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      ctl_q   <= FOPADD;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            ctl_q   <= icontrol;
            a_q     <= idataa;
            b_q     <= idatab;
            cnt_q   <= lat_m1_d;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (iflush) begin
            state_q <= S_IDLE;
          end else if (capture) begin
            res_q   <= ifpa_result;
            flg_q   <= {ifpa_nan, ifpa_zero,
                        ifpa_overflow,
                        ifpa_underflow, ifpa_comp};
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

`ifdef FPSEQ_STICKY_FLAGS_EN
  logic [2:0] sticky_q;
  logic [2:0] new_flg;

  assign new_flg = {ifpa_nan, ifpa_overflow,
                    ifpa_underflow};

  // A clear coinciding with a capture keeps only
  // the flags of the op being captured.
  always_ff @(posedge iclock or negedge irst_n) begin
    if (!irst_n) begin
      sticky_q <= '0;
    end else if (ifflags_clr) begin
      sticky_q <= capture ? new_flg : 3'b000;
    end else if (capture) begin
      sticky_q <= sticky_q | new_flg;
    end
  end

  assign offlags = sticky_q;
`endif

  assign obusy        = (state_q == S_WAIT);
  assign odone        = done_q;
  assign oresult      = res_q;
  assign onan         = flg_q[4];
  assign ozero        = flg_q[3];
  assign ooverflow    = flg_q[2];
  assign ounderflow   = flg_q[1];
  assign oCompResult  = flg_q[0];
  assign ofpa_control = ctl_q;
  assign ofpa_dataa   = a_q;
  assign ofpa_datab   = b_q;

endmodule

// File: tb/tb_fpalu_sequencer.sv
// tb_fpalu_sequencer: randomized bench for fpalu_sequencer.
// The bench plays the FPALU and tracks each op by its absolute capture cycle.
module tb_fpalu_sequencer;
  import fpalu_sequencer_pkg::*;

  logic        iclock = 1'b0;
  logic        irst_n = 1'b0;
  logic        istart = 1'b0;
  logic [4:0]  icontrol = '0;
  logic [31:0] idataa = '0;
  logic [31:0] idatab = '0;
  logic        iflush = 1'b0;
  logic        obusy, odone;
  logic [31:0] oresult;
  logic        onan, ozero, ooverflow;
  logic        ounderflow, oCompResult;
  logic [4:0]  ofpa_control;
  logic [31:0] ofpa_dataa, ofpa_datab;
  logic [31:0] ifpa_result = '0;
  logic        ifpa_nan = 1'b0;
  logic        ifpa_zero = 1'b0;
  logic        ifpa_overflow = 1'b0;
  logic        ifpa_underflow = 1'b0;
  logic        ifpa_comp = 1'b0;
`ifdef FPSEQ_STICKY_FLAGS_EN
  logic        ifflags_clr = 1'b0;
  logic [2:0]  offlags;
`endif

  fpalu_sequencer dut (
    .iclock(iclock), .irst_n(irst_n),
    .istart(istart), .icontrol(icontrol),
    .idataa(idataa), .idatab(idatab),
    .iflush(iflush),
`ifdef FPSEQ_STICKY_FLAGS_EN
    .ifflags_clr(ifflags_clr),
    .offlags(offlags),
`endif
    .obusy(obusy), .odone(odone),
    .oresult(oresult), .onan(onan),
    .ozero(ozero), .ooverflow(ooverflow),
    .ounderflow(ounderflow),
    .oCompResult(oCompResult),
    .ofpa_control(ofpa_control),
    .ofpa_dataa(ofpa_dataa),
    .ofpa_datab(ofpa_datab),
    .ifpa_result(ifpa_result),
    .ifpa_nan(ifpa_nan), .ifpa_zero(ifpa_zero),
    .ifpa_overflow(ifpa_overflow),
    .ifpa_underflow(ifpa_underflow),
    .ifpa_comp(ifpa_comp)
  );

  always #5 iclock = ~iclock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Reference: one pending op with an absolute capture cycle.
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_cap = 0;
  bit          m_done = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_flags = '0;
  logic [4:0]  m_ctl = FOPADD;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [2:0]  m_sticky = '0;

  function automatic int lat_of(logic [4:0] op);
    if (op == FOPADD || op == FOPSUB) return 7;
    if (op == FOPMUL) return 5;
    if (op == FOPDIV) return 6;
    if (op == FOPSQRT) return 16;
    if (op >= FOPCVTSW && op <= FOPCVTWUS)
      return 6;
    return 1;
  endfunction

  task automatic compare_all();
    chk("busy", obusy, m_busy);
    chk("done", odone, m_done);
    chk("result", oresult, m_res);
    chk("flags", {onan, ozero, ooverflow,
                  ounderflow, oCompResult}, m_flags);
    chk("fpa_ctl", ofpa_control, m_ctl);
    chk("fpa_a", ofpa_dataa, m_a);
    chk("fpa_b", ofpa_datab, m_b);
`ifdef FPSEQ_STICKY_FLAGS_EN
    chk("sticky", offlags, m_sticky);
`endif
  endtask

  // Inputs are set at negedge; one clock edge, then compare.
  task automatic step();
    bit cap;
    @(posedge iclock);
    cyc++;
    cap = 0;
    m_done = 0;
    if (m_busy) begin
      if (iflush) m_busy = 0;
      else if (cyc == m_cap) cap = 1;
    end else if (istart && !iflush) begin
      m_busy = 1;
      m_cap = cyc + lat_of(icontrol);
      m_ctl = icontrol;
      m_a = idataa;
      m_b = idatab;
    end
    if (cap) begin
      m_busy = 0;
      m_done = 1;
      m_res = ifpa_result;
      m_flags = {ifpa_nan, ifpa_zero, ifpa_overflow,
                 ifpa_underflow, ifpa_comp};
    end
`ifdef FPSEQ_STICKY_FLAGS_EN
    if (ifflags_clr)
      m_sticky = cap ? {ifpa_nan, ifpa_overflow,
                        ifpa_underflow} : 3'b000;
    else if (cap)
      m_sticky |= {ifpa_nan, ifpa_overflow,
                   ifpa_underflow};
`endif
    #1;
    compare_all();
    @(negedge iclock);
  endtask

  task automatic check_reset();
    chk("rst_busy", obusy, 0);
    chk("rst_done", odone, 0);
    chk("rst_result", oresult, 0);
    chk("rst_flags", {onan, ozero, ooverflow,
                      ounderflow, oCompResult}, 0);
    chk("rst_ctl", ofpa_control, FOPADD);
    chk("rst_a", ofpa_dataa, 0);
    chk("rst_b", ofpa_datab, 0);
`ifdef FPSEQ_STICKY_FLAGS_EN
    chk("rst_sticky", offlags, 0);
`endif
    m_busy = 0; m_done = 0; m_res = '0;
    m_flags = '0; m_ctl = FOPADD;
    m_a = '0; m_b = '0; m_sticky = '0;
  endtask

  task automatic set_fpa(logic [31:0] r,
                         logic [4:0] f);
    ifpa_result = r;
    {ifpa_nan, ifpa_zero, ifpa_overflow,
     ifpa_underflow, ifpa_comp} = f;
  endtask

  task automatic issue(logic [4:0] op,
                       logic [31:0] a,
                       logic [31:0] b);
    istart = 1; icontrol = op;
    idataa = a; idatab = b;
    step();
    istart = 0;
  endtask

  // Counts edges after the accept edge until odone.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (odone) break;
      step();
      n++;
    end
  endtask

  task automatic rnd_in(int ps, int pf);
    istart = ($urandom_range(99) < ps);
    iflush = ($urandom_range(99) < pf);
    icontrol = 5'($urandom_range(20));
    idataa = $urandom;
    idatab = $urandom;
    set_fpa($urandom, 5'($urandom));
`ifdef FPSEQ_STICKY_FLAGS_EN
    ifflags_clr = ($urandom_range(99) < 5);
`endif
  endtask

  int n;
  logic [31:0] hold_ctl;

  initial begin
    #12;
    check_reset();
    @(negedge iclock);
    irst_n = 1;
    step();

    // 1+2 = 3
    set_fpa(32'h40400000, 5'b0);
    issue(FOPADD, 32'h3F800000, 32'h40000000);
    wait_done(n);
    chk("add_lat", n, 7);
    chk("add_res", oresult, 32'h40400000);

    // sqrt(16) = 4, stray istart during WAIT
    set_fpa(32'h40800000, 5'b0);
    issue(FOPSQRT, 32'h41800000, 32'h0);
    n = 0;
    for (int i = 0; i < 40 && !odone; i++) begin
      istart = 1'($urandom_range(1));
      icontrol = 5'($urandom_range(18));
      idataa = $urandom;
      step();
      n++;
    end
    istart = 0;
    chk("sqrt_lat", n, 16);
    chk("sqrt_res", oresult, 32'h40800000);
    chk("sqrt_ctl", ofpa_control, FOPSQRT);

    // MUL then CLT issued in the odone cycle
    set_fpa(32'h40000000, 5'b0);
    issue(FOPMUL, 32'h3F800000, 32'h40000000);
    wait_done(n);
    chk("mul_lat", n, 5);
    ifpa_comp = ($bitstoshortreal(32'h3F800000) <
                 $bitstoshortreal(32'h40000000));
    issue(FOPCLT, 32'h3F800000, 32'h40000000);
    wait_done(n);
    chk("clt_lat", n, 1);
    chk("clt_cmp", oCompResult, 1);

    // DIV flushed at T+3, new op at T+4
    hold_ctl = oresult;
    set_fpa(32'h12345678, 5'b10101);
    issue(FOPDIV, 32'h3F800000, 32'h40000000);
    step(); step();
    iflush = 1;
    step();
    iflush = 0;
    chk("flush_busy", obusy, 0);
    chk("flush_keep", oresult, hold_ctl);
    issue(FOPMUL, 32'h1, 32'h2);
    chk("post_flush_busy", obusy, 1);
    wait_done(n);
    chk("post_flush_lat", n, 5);

    // async reset mid-DIV
    issue(FOPDIV, 32'hABCD0000, 32'h1234);
    step();
    #2 irst_n = 0;
    #1 check_reset();
    @(negedge iclock);
    irst_n = 1;
    for (int i = 0; i < 10; i++) step();

`ifdef FPSEQ_STICKY_FLAGS_EN
    set_fpa(32'h7F800000, 5'b00100);
    issue(FOPDIV, 32'h3F800000, 32'h0);
    wait_done(n);
    set_fpa(32'h40000000, 5'b0);
    issue(FOPADD, 32'h3F800000, 32'h3F800000);
    wait_done(n);
    chk("sticky_kept", offlags, 3'b010);
    ifflags_clr = 1;
    step();
    ifflags_clr = 0;
    chk("sticky_clr", offlags, 3'b000);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rnd_in(40, 6);
      step();
    end
    istart = 0; iflush = 0;
    for (int i = 0; i < 20; i++) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
